// File: rtl/ps2_key_pkg.sv
// Shared constants and decoder state encoding for the PS/2 key tracker.
// Scan Code Set 2 prefixes plus the width of a table entry {ext, code}.
package ps2_key_pkg;

  localparam int CODE_W = 9;
  localparam int PAUSE_TAIL = 7;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  typedef enum logic [2:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK,
    DEC_SKIP
  } dec_state_e;

endpackage

// File: rtl/ps2_key_matrix_tracker_decoder.sv
// Scan Code Set 2 prefix decoder: turns the byte stream into
// one-cycle {ext, code} make/break strobes, swallowing the Pause burst.
module ps2_scan_decoder
  import ps2_key_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              code_valid,
  output logic [CODE_W-1:0] code,
  output logic              is_make
);

  dec_state_e state, state_next;
  logic [2:0] skip, skip_next;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= DEC_IDLE;
      skip  <= '0;
    end else begin
      state <= state_next;
      skip  <= skip_next;
    end
  end

  always_comb begin
    state_next = state;
    skip_next  = skip;
    code_valid = 1'b0;
    code       = {1'b0, byte_data};
    is_make    = 1'b1;
    if (byte_valid) begin
      unique case (state)
        DEC_IDLE: begin
          unique case (1'b1)
            byte_data == PS2_EXT:   state_next = DEC_EXT;
            byte_data == PS2_BREAK: state_next = DEC_BRK;
            byte_data == PS2_PAUSE: begin
              state_next = DEC_SKIP;
              skip_next  = 3'(PAUSE_TAIL);
            end
            default: code_valid = 1'b1;
          endcase
        end
        DEC_EXT: begin
          if (byte_data == PS2_BREAK) begin
            state_next = DEC_EXT_BRK;
          end else begin
            code_valid = 1'b1;
            code       = {1'b1, byte_data};
            state_next = DEC_IDLE;
          end
        end
        DEC_BRK: begin
          code_valid = 1'b1;
          is_make    = 1'b0;
          state_next = DEC_IDLE;
        end
        DEC_EXT_BRK: begin
          code_valid = 1'b1;
          code       = {1'b1, byte_data};
          is_make    = 1'b0;
          state_next = DEC_IDLE;
        end
        DEC_SKIP: begin
          skip_next = skip - 3'd1;
          if (skip == 3'd1) state_next = DEC_IDLE;
        end
        default: state_next = DEC_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_matrix_tracker.sv
// Parametrised PS/2 key table tracker: held/pulse outputs,
// optional auto-repeat and a one-entry make/break event register.
module ps2_key_matrix_tracker
  import ps2_key_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 8,
  parameter logic [NUM_KEYS*CODE_W-1:0] KEY_CODES = '0,
  parameter logic [NUM_KEYS-1:0] PULSE_MASK = '1,
  parameter int unsigned REPEAT_EN = 0,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic [NUM_KEYS-1:0] keys_held,
  output logic [NUM_KEYS-1:0] keys_out,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [(NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1)-1:0] evt_key,
  output logic                evt_make,
  output logic                evt_overflow
);

  localparam int KEY_W = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;

  logic              code_valid;
  logic [CODE_W-1:0] code;
  logic              is_make;

  ps2_scan_decoder u_dec (
    .clock      (clock),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .code_valid (code_valid),
    .code       (code),
    .is_make    (is_make)
  );

  logic                hit;
  logic [KEY_W-1:0]    idx;
  logic [NUM_KEYS-1:0] hot;

  // Descending scan so the lowest matching index is the one kept.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    hot = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[i*CODE_W +: CODE_W] == code) begin
        hit    = 1'b1;
        idx    = KEY_W'(i);
        hot    = '0;
        hot[i] = 1'b1;
      end
    end
  end

  logic held_sel, pulse_sel, make_new, brk_hit, push;

  assign held_sel  = |(keys_held & hot);
  assign pulse_sel = |(PULSE_MASK & hot);
  assign make_new  = code_valid && is_make && hit && !held_sel;
  assign brk_hit   = code_valid && !is_make && hit && held_sel;
  assign push      = make_new || brk_hit;

  logic                rep_active;
  logic [NUM_KEYS-1:0] rep_hot;
  logic [31:0]         rep_cnt;
  logic                rep_load, rep_stop, fire;
  logic [NUM_KEYS-1:0] pulse_q;

  assign rep_load = (REPEAT_EN != 0) && make_new && pulse_sel;
  assign rep_stop = brk_hit && |(hot & rep_hot);
  assign fire     = rep_active && rep_cnt == 32'd1 && !rep_load && !rep_stop;

  always_ff @(posedge clock) begin
    if (!reset) begin
      keys_held  <= '0;
      pulse_q    <= '0;
      rep_active <= 1'b0;
      rep_hot    <= '0;
      rep_cnt    <= '0;
    end else begin
      if (make_new) keys_held <= keys_held | hot;
      else if (brk_hit) keys_held <= keys_held & ~hot;
      pulse_q <= (make_new ? hot : '0) | (fire ? rep_hot : '0);
      if (rep_load) begin
        rep_active <= 1'b1;
        rep_hot    <= hot;
        rep_cnt    <= 32'(REPEAT_DELAY);
      end else if (rep_stop) begin
        rep_active <= 1'b0;
      end else if (rep_active) begin
        if (rep_cnt == 32'd1) rep_cnt <= 32'(REPEAT_PERIOD);
        else rep_cnt <= rep_cnt - 32'd1;
      end
    end
  end

  assign keys_out = (pulse_q & PULSE_MASK) | (keys_held & ~PULSE_MASK);

  always_ff @(posedge clock) begin
    if (!reset) begin
      evt_valid    <= 1'b0;
      evt_key      <= '0;
      evt_make     <= 1'b0;
      evt_overflow <= 1'b0;
    end else if (push && (!evt_valid || evt_ready)) begin
      evt_valid <= 1'b1;
      evt_key   <= idx;
      evt_make  <= make_new;
    end else if (push) begin
      evt_overflow <= 1'b1;
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_matrix_tracker.sv
// Directed bench: byte sequences in, held/pulse outputs checked inline,
// events checked against a scoreboard queue as they are consumed.
module tb_ps2_key_matrix_tracker;

  localparam logic [26:0] CODES = {9'h01D, 9'h174, 9'h11D};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       evt_ready = 1'b1;
  logic       rdy1 = 1'b1;

  logic [2:0] held, kout, held1, kout1;
  logic       ev, make, ovf, ev1, make1, ovf1;
  logic [1:0] key, key1;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] exp_q[$];

  always #5 clock = ~clock;

  ps2_key_matrix_tracker #(
    .NUM_KEYS(3), .KEY_CODES(CODES), .PULSE_MASK(3'b101)
  ) u0 (
    .clock(clock), .reset(reset),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .keys_held(held), .keys_out(kout),
    .evt_valid(ev), .evt_ready(evt_ready),
    .evt_key(key), .evt_make(make), .evt_overflow(ovf)
  );

  ps2_key_matrix_tracker #(
    .NUM_KEYS(3), .KEY_CODES(CODES), .PULSE_MASK(3'b101),
    .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) u1 (
    .clock(clock), .reset(reset),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .keys_held(held1), .keys_out(kout1),
    .evt_valid(ev1), .evt_ready(rdy1),
    .evt_key(key1), .evt_make(make1), .evt_overflow(ovf1)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumes an event whenever the handshake will fire on the next edge.
  task automatic tick();
    logic [2:0] e;
    if (ev === 1'b1 && evt_ready) begin
      if (exp_q.size() == 0) begin
        check("evt_unexpected", {29'd0, key, make}, 32'h7);
      end else begin
        e = exp_q.pop_front();
        check("evt", {29'd0, key, make}, {29'd0, e});
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_held", held, 0);
    check("rst_out", kout, 0);
    check("rst_evt", ev, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b1;
    tick();

    // plain key 2 press / release
    send(8'h1D); exp_q.push_back({2'd2, 1'b1});
    check("k2_held", held, 3'b100);
    check("k2_pulse", kout, 3'b100);
    tick();
    check("k2_pulse_end", kout, 3'b000);
    send(8'hF0);
    check("k2_brk_pre", held, 3'b100);
    send(8'h1D); exp_q.push_back({2'd2, 1'b0});
    check("k2_rel", held, 3'b000);

    // extended hold-mode key 1
    send(8'hE0);
    send(8'h74); exp_q.push_back({2'd1, 1'b1});
    check("k1_held", held, 3'b010);
    check("k1_out", kout, 3'b010);
    repeat (3) tick();
    check("k1_hold", kout, 3'b010);
    send(8'h74);
    check("k1_plain74", held, 3'b010);
    send(8'hE0);
    send(8'hF0);
    check("k1_brk_pre", kout, 3'b010);
    send(8'h74); exp_q.push_back({2'd1, 1'b0});
    check("k1_rel", held, 3'b000);
    check("k1_out_rel", kout, 3'b000);

    // typematic repeats from the keyboard are ignored
    send(8'h1D); exp_q.push_back({2'd2, 1'b1});
    check("typ_pulse", kout, 3'b100);
    send(8'h1D);
    check("typ_2", kout, 3'b000);
    send(8'h1D);
    check("typ_3", kout, 3'b000);
    check("typ_held", held, 3'b100);
    send(8'hF0);
    send(8'h1D); exp_q.push_back({2'd2, 1'b0});

    // Pause burst, then a tail of table codes that must be swallowed
    foreach (CODES[i]) begin end
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_held", held, 3'b000);
    send(8'hE1);
    repeat (7) send(8'h1D);
    check("skip_held", held, 3'b000);
    check("skip_out", kout, 3'b000);
    send(8'h1D); exp_q.push_back({2'd2, 1'b1});
    check("post_skip", held, 3'b100);
    check("post_skip_out", kout, 3'b100);
    send(8'hF0);
    send(8'h1D); exp_q.push_back({2'd2, 1'b0});
    repeat (2) tick();

    // overflow while stalled, then simultaneous pop/push
    evt_ready = 1'b0;
    send(8'hE0);
    send(8'h1D); exp_q.push_back({2'd0, 1'b1});
    check("ov_valid", ev, 1);
    send(8'h1D);
    check("ov_flag", ovf, 1);
    check("ov_stable", {key, make}, 3'b001);
    check("ov_held", held, 3'b101);
    send(8'hF0);
    evt_ready = 1'b1;
    send(8'h1D); exp_q.push_back({2'd2, 1'b0});
    check("swap_valid", ev, 1);
    check("swap_evt", {key, make}, 3'b100);
    check("ov_sticky", ovf, 1);
    send(8'hE0);
    send(8'hF0);
    send(8'h1D); exp_q.push_back({2'd0, 1'b0});
    repeat (2) tick();

    // auto-repeat on u1: pulses at +1, +11, +15, +19
    send(8'hE0);
    send(8'h1D); exp_q.push_back({2'd0, 1'b1});
    check("rep_c1", kout1[0], 1);
    for (int c = 2; c <= 20; c++) begin
      tick();
      check($sformatf("rep_c%0d", c), kout1[0],
            (c == 11 || c == 15 || c == 19) ? 1 : 0);
      if (c == 11) check("norep_u0", kout[0], 0);
    end
    send(8'hE0);
    check("rep_c21", kout1[0], 0);
    send(8'hF0);
    check("rep_c22", kout1[0], 0);
    send(8'h1D); exp_q.push_back({2'd0, 1'b0});
    check("rep_c23_brk", kout1[0], 0);
    check("rep_rel", held1, 3'b000);
    for (int c = 24; c <= 33; c++) begin
      tick();
      check($sformatf("rep_off%0d", c), kout1[0], 0);
    end

    // reset mid-sequence after E0 F0
    send(8'hE0);
    send(8'h74); exp_q.push_back({2'd1, 1'b1});
    repeat (2) tick();
    send(8'hE0);
    send(8'hF0);
    reset = 1'b0;
    tick();
    check("mr_held", held, 3'b000);
    check("mr_out", kout, 3'b000);
    check("mr_evt", ev, 0);
    check("mr_ovf", ovf, 0);
    reset = 1'b1;
    tick();
    send(8'h74);
    check("mr_74", held, 3'b000);
    tick();
    check("mr_no_evt", ev, 0);

    repeat (2) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
